ex_muldiv_sequencer: RTL and testbench

EX_MULDIV_SEQUENCER -- requirements
Module: ex_muldiv_sequencer

---
 rtl/ex_muldiv_sequencer_pkg.sv | 37 +++
 rtl/ex_muldiv_sequencer_if.sv | 23 ++
 rtl/muldiv_datapath.sv | 105 ++++++++++
 rtl/ex_muldiv_sequencer.sv | 66 ++++++
 tb/tb_ex_muldiv_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared pipeline definitions for the EX-stage M-extension sequencer:
// FUNC3 encodings, FSM state encoding and operand-signedness helpers.
package ex_muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        F_MUL    = 3'b000,
        F_MULH   = 3'b001,
        F_MULHSU = 3'b010,
        F_MULHU  = 3'b011,
        F_DIV    = 3'b100,
        F_DIVU   = 3'b101,
        F_REM    = 3'b110,
        F_REMU   = 3'b111
    } func3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic is_div(func3_e f);
        return (f == F_DIV) || (f == F_DIVU) ||
               (f == F_REM) || (f == F_REMU);
    endfunction

    function automatic logic op1_signed(func3_e f);
        return (f == F_MULH) || (f == F_MULHSU) ||
               (f == F_DIV) || (f == F_REM);
    endfunction

    function automatic logic op2_signed(func3_e f);
        return (f == F_MULH) || (f == F_DIV) || (f == F_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_if.sv
// EX-stage <-> mul/div sequencer handshake and operand bundle.
interface ex_muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            START;
    logic [2:0]      FUNC3;
    logic [XLEN-1:0] OPERAND_1;
    logic [XLEN-1:0] OPERAND_2;
    logic            FLUSH;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] RESULT;

    modport master (
        output START, FUNC3, OPERAND_1, OPERAND_2, FLUSH,
        input  BUSY, DONE, RESULT
    );

    modport slave (
        input  START, FUNC3, OPERAND_1, OPERAND_2, FLUSH,
        output BUSY, DONE, RESULT
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Iterative mul/div datapath: 2*XLEN accumulator, shift-add and
// restoring shift-subtract step, sign fix-up and result register.
module muldiv_datapath
    import ex_muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            wr_fix,
    input  logic            wr_special,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            special,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    func3_e            f_in, f_q;
    logic              sgn1, sgn2, s1_q, s2_q;
    logic [XLEN-1:0]   mag1, mag2, mag1_q, mag2_q;
    logic [2*XLEN-1:0] acc_q, acc_mul, acc_div, prod;
    logic [XLEN:0]     sum, add, rem_sh, diff;
    logic [XLEN-1:0]   quo, rem, fix_res, spec_res, result_q;
    logic              div_zero, div_ovf;

    assign f_in = func3_e'(func3);
    assign sgn1 = op1[XLEN-1] & op1_signed(f_in);
    assign sgn2 = op2[XLEN-1] & op2_signed(f_in);
    assign mag1 = sgn1 ? -op1 : op1;
    assign mag2 = sgn2 ? -op2 : op2;

    assign div_zero = is_div(f_in) && (op2 == '0);
    assign div_ovf  = ((f_in == F_DIV) || (f_in == F_REM)) &&
                      (op1 == MIN_NEG) && (op2 == '1);
    assign special  = div_zero | div_ovf;

    // func3[1] separates remainder from quotient among the divides
    always_comb begin
        spec_res = '0;
        if (div_zero)
            spec_res = func3[1] ? op1 : '1;
        else if (div_ovf)
            spec_res = func3[1] ? '0 : op1;
    end

    assign sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mag1_q};
    assign add     = acc_q[0] ? sum : {1'b0, acc_q[2*XLEN-1:XLEN]};
    assign acc_mul = {add, acc_q[XLEN-1:1]};

    assign rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    assign diff    = rem_sh - {1'b0, mag2_q};
    assign acc_div = diff[XLEN] ?
                     {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0} :
                     {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign prod = (s1_q ^ s2_q) ? -acc_q : acc_q;
    assign quo  = (s1_q ^ s2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem  = s1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = rem;
        unique case (f_q)
            F_MUL:                     fix_res = prod[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:             fix_res = quo;
            F_REM, F_REMU:             fix_res = rem;
            default:                   fix_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q      <= F_MUL;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            mag1_q   <= '0;
            mag2_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            if (load) begin
                f_q    <= f_in;
                s1_q   <= sgn1;
                s2_q   <= sgn2;
                mag1_q <= mag1;
                mag2_q <= mag2;
                acc_q  <= {{XLEN{1'b0}}, is_div(f_in) ? mag1 : mag2};
            end else if (step) begin
                acc_q  <= is_div(f_q) ? acc_div : acc_mul;
            end
            if (wr_special)
                result_q <= spec_res;
            else if (wr_fix)
                result_q <= fix_res;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage M-extension sequencer: FSM, iteration counter and
// pipeline stall/complete handshake around muldiv_datapath.
module ex_muldiv_sequencer
    import ex_muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic             CLK,
    input logic             RESET,
    ex_muldiv_sequencer_if.slave bus
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q;
    logic        accept, special, step, wr_fix, wr_special;

    assign accept     = (state_q == S_IDLE) & bus.START & ~bus.FLUSH;
    assign wr_special = accept & special;
    assign step       = (state_q == S_CALC) & ~bus.FLUSH;
    assign wr_fix     = (state_q == S_FIX) & ~bus.FLUSH;

    assign bus.BUSY = accept | (state_q == S_CALC) | (state_q == S_FIX);
    assign bus.DONE = (state_q == S_DONE) & ~bus.FLUSH;

    always_ff @(posedge CLK) begin
        if (RESET)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == 6'(XLEN-1)) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.FLUSH)
            state_d = S_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RESET || accept)
            cnt_q <= '0;
        else if (step)
            cnt_q <= cnt_q + 6'd1;
    end

    muldiv_datapath #(.XLEN(XLEN)) u_dp (
        .clk        (CLK),
        .rst        (RESET),
        .load       (accept),
        .step       (step),
        .wr_fix     (wr_fix),
        .wr_special (wr_special),
        .func3      (bus.FUNC3),
        .op1        (bus.OPERAND_1),
        .op2        (bus.OPERAND_2),
        .special    (special),
        .result     (bus.RESULT)
    );

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed-vector bench for ex_muldiv_sequencer: table of ops plus
// flush, reset-abort and held-START sequences.
module tb_ex_muldiv_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ex_muldiv_sequencer_if #(.XLEN(32)) bus_if ();

    ex_muldiv_sequencer #(.XLEN(32)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t v[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat, output int busy_n,
                          output logic busy_at_done);
        res = 'x;
        lat = 0;
        busy_n = 0;
        busy_at_done = 1'b1;
        @(negedge clk);
        bus_if.START = 1'b1;
        bus_if.FUNC3 = f;
        bus_if.OPERAND_1 = a;
        bus_if.OPERAND_2 = b;
        #1;
        if (bus_if.BUSY) busy_n++;
        @(posedge clk);
        #1 bus_if.START = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus_if.DONE) begin
                lat = k;
                res = bus_if.RESULT;
                busy_at_done = bus_if.BUSY;
                break;
            end
            if (bus_if.BUSY) busy_n++;
        end
    endtask

    task automatic watch_quiet(input string name, input int n);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus_if.DONE || bus_if.BUSY) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        int          lat, busy_n;
        logic        bad;

        checks = 0;
        failures = 0;

        v[0]  = '{"mul_7_m3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        v[1]  = '{"mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        v[2]  = '{"mulhsu_m1_2",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34};
        v[3]  = '{"mulh_min_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34};
        v[4]  = '{"mul_shift",    3'b000, 32'h12345678, 32'h10,       32'h23456780, 34};
        v[5]  = '{"div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
        v[6]  = '{"rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
        v[7]  = '{"divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       34};
        v[8]  = '{"remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,        34};
        v[9]  = '{"div_7_m2",     3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
        v[10] = '{"divu_5_0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        v[11] = '{"rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        v[12] = '{"div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        v[13] = '{"rem_9_0",      3'b110, 32'd9,        32'd0,        32'd9,        1};

        rst = 1'b1;
        bus_if.START = 1'b0;
        bus_if.FLUSH = 1'b0;
        bus_if.FUNC3 = '0;
        bus_if.OPERAND_1 = '0;
        bus_if.OPERAND_2 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(bus_if.BUSY), 32'd0);
        chk("reset_done", 32'(bus_if.DONE), 32'd0);
        chk("reset_result", bus_if.RESULT, 32'd0);

        foreach (v[i]) begin
            run_op(v[i].f, v[i].a, v[i].b, res, lat, busy_n, bad);
            chk({v[i].name, "_result"}, res, v[i].exp);
            chk({v[i].name, "_latency"}, 32'(lat), 32'(v[i].lat));
            chk({v[i].name, "_busy_cycles"}, 32'(busy_n), 32'(v[i].lat));
            chk({v[i].name, "_busy_in_done"}, 32'(bad), 32'd0);
            @(negedge clk);
            chk({v[i].name, "_done_one_cycle"}, 32'(bus_if.DONE), 32'd0);
            chk({v[i].name, "_result_hold"}, bus_if.RESULT, v[i].exp);
        end

        @(negedge clk);
        bus_if.START = 1'b1;
        bus_if.FUNC3 = 3'b000;
        bus_if.OPERAND_1 = 32'd3;
        bus_if.OPERAND_2 = 32'd5;
        @(posedge clk);
        #1 bus_if.START = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus_if.FLUSH = 1'b1;
        bus_if.START = 1'b1;
        @(posedge clk);
        #1;
        bus_if.FLUSH = 1'b0;
        bus_if.START = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(bus_if.BUSY), 32'd0);
        chk("flush_done", 32'(bus_if.DONE), 32'd0);
        chk("flush_result", bus_if.RESULT, v[13].exp);
        watch_quiet("flush_no_done", 40);
        run_op(3'b000, 32'd3, 32'd5, res, lat, busy_n, bad);
        chk("after_flush_result", res, 32'd15);
        chk("after_flush_latency", 32'(lat), 32'd34);

        @(negedge clk);
        bus_if.START = 1'b1;
        bus_if.FUNC3 = 3'b101;
        bus_if.OPERAND_1 = 32'd1000;
        bus_if.OPERAND_2 = 32'd10;
        @(posedge clk);
        #1 bus_if.START = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus_if.BUSY), 32'd0);
        chk("abort_done", 32'(bus_if.DONE), 32'd0);
        chk("abort_result", bus_if.RESULT, 32'd0);
        watch_quiet("abort_no_done", 40);

        @(negedge clk);
        bus_if.START = 1'b1;
        bus_if.FUNC3 = 3'b000;
        bus_if.OPERAND_1 = 32'd6;
        bus_if.OPERAND_2 = 32'd7;
        lat = 0;
        res = 'x;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus_if.DONE) begin
                lat = k;
                res = bus_if.RESULT;
                break;
            end
        end
        chk("held_start_latency", 32'(lat), 32'd34);
        chk("held_start_result", res, 32'd42);
        @(posedge clk);
        #1 bus_if.START = 1'b0;
        watch_quiet("held_start_no_rerun", 40);
        chk("held_start_result_hold", bus_if.RESULT, 32'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
